// File: rtl/sliced_addsub_if.sv
// Handshake and operand/result bundle for the sliced add/subtract unit.
// The master side issues operations; the slave side (the datapath) returns results and flags.
interface sliced_addsub_if #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             subtract;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;
   logic             zero;

   modport master (
      output start, a, b, cin, subtract,
      input  busy, done, sum, cout, overflow, zero
   );

   modport slave (
      input  start, a, b, cin, subtract,
      output busy, done, sum, cout, overflow, zero
   );
endinterface

// File: rtl/sliced_addsub_seq.sv
// Multi-cycle add/subtract: WIDTH-bit operands go through one SLICE-bit adder, LSB slice first.
// Define SLICED_ADDSUB_SATURATE_EN to clamp the sum on signed overflow instead of wrapping.
//
// state | meaning
// IDLE  | waiting for start; operands not yet captured
// RUN   | one slice added per clock, carry held in carry_q
// DONE  | results valid, done pulses; start here chains the next operation
module sliced_addsub_seq #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input logic            clk,
   input logic            reset,
   sliced_addsub_if.slave bus
);
   localparam int K     = WIDTH / SLICE;
   localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry_q;
   logic [IDX_W-1:0] idx_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;
   logic             zero_q;

   logic             accept;
   logic             last_slice;
   logic [SLICE-1:0] a_sl;
   logic [SLICE-1:0] b_sl;
   logic [SLICE:0]   slice_full;
   logic             c_msb_in;
   logic             slice_ovf;
   logic [WIDTH-1:0] sum_merge;
   logic [WIDTH-1:0] sum_final;

   assign accept     = bus.start && ((state_q == IDLE) || (state_q == DONE));
   assign last_slice = (idx_q == LAST_IDX);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (last_slice) state_d = DONE;
         DONE:    state_d = accept ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operands are shifted right each slice so the adder always reads the low SLICE bits.
   assign a_sl       = a_sh[SLICE-1:0];
   assign b_sl       = b_sh[SLICE-1:0];
   assign slice_full = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};

   // Carry into the slice MSB recovered from its sum bit; on the last slice this is the carry into bit WIDTH-1.
   assign c_msb_in   = slice_full[SLICE-1] ^ a_sl[SLICE-1] ^ b_sl[SLICE-1];
   assign slice_ovf  = c_msb_in ^ slice_full[SLICE];

   always_comb begin
      sum_merge = sum_q;
      sum_merge[int'(idx_q)*SLICE +: SLICE] = slice_full[SLICE-1:0];
   end

`ifdef SLICED_ADDSUB_SATURATE_EN
   // On overflow both effective operands share a_sl's MSB, which is the true result's sign.
   always_comb begin
      sum_final = sum_merge;
      if (last_slice && slice_ovf) begin
         sum_final = a_sl[SLICE-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end
`else
   assign sum_final = sum_merge;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         a_sh    <= '0;
         b_sh    <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else if (accept) begin
         a_sh    <= bus.a;
         b_sh    <= bus.subtract ? ~bus.b : bus.b;
         carry_q <= bus.subtract ? ~bus.cin : bus.cin;
         idx_q   <= '0;
      end else if (state_q == RUN) begin
         a_sh    <= a_sh >> SLICE;
         b_sh    <= b_sh >> SLICE;
         carry_q <= slice_full[SLICE];
         idx_q   <= idx_q + 1'b1;
         sum_q   <= sum_final;
         if (last_slice) begin
            cout_q <= slice_full[SLICE];
            ovf_q  <= slice_ovf;
            zero_q <= (sum_final == '0);
         end
      end
   end

   assign bus.busy     = (state_q == RUN);
   assign bus.done     = (state_q == DONE);
   assign bus.sum      = sum_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = ovf_q;
   assign bus.zero     = zero_q;
endmodule
